// File: rtl/step_cmd_loader.sv
// Command loader for a step-pulse generator: a small command FIFO feeding a
// strobe/handshake FSM that presents one command at a time on N with a 2-cycle WR strobe.
module step_cmd_loader #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               cmd_data,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               N,
    output logic                     WR,
    input  logic                     busy,
    output logic                     idle,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STB1    = 3'd1,
        S_STB2    = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      n_q, n_d;
    logic            wr_q, wr_d;
    logic            idle_q, idle_d;
    logic            err_q, err_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            push_s;
    logic            pop_s;

    assign cmd_ready  = (level_q < LW'(DEPTH));
    assign fifo_level = level_q;
    assign N          = n_q;
    assign WR         = wr_q;
    assign idle       = idle_q;
    assign err        = err_q;

    // FIFO bookkeeping: pops happen only from IDLE, so at most one command is in flight
    always_comb begin
        push_s   = cmd_valid && (level_q < LW'(DEPTH));
        pop_s    = (state_q == S_IDLE) && (level_q != {LW{1'b0}});
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Strobe/handshake sequencing and timeout detection while waiting for busy
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        err_d   = err_q;
        n_d     = n_q;
        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    state_d = S_STB1;
                    n_d     = mem_q[rd_ptr_q];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STB1: state_d = S_STB2;
            S_STB2: begin
                state_d = S_WAIT_HI;
                timer_d = {TW{1'b0}};
            end
            S_WAIT_HI: begin
                if (busy) begin
                    state_d = S_WAIT_LO;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT_LO: begin
                if (!busy) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_LO;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // WR and idle are registered from the next state so they align with the state they describe
        wr_d   = !((state_d == S_STB1) || (state_d == S_STB2));
        idle_d = (state_d == S_IDLE) && (level_d == {LW{1'b0}});
    end

    // Command storage; a reset cycle never writes
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            mem_q[wr_ptr_q] <= cmd_data;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
            n_q      <= 8'h00;
            wr_q     <= 1'b1;
            idle_q   <= 1'b1;
            err_q    <= 1'b0;
            timer_q  <= {TW{1'b0}};
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            n_q      <= n_d;
            wr_q     <= wr_d;
            idle_q   <= idle_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
        end
    end

endmodule

// File: tb/tb_step_cmd_loader.sv
// Self-checking bench for step_cmd_loader: directed scenarios plus a randomized run
// scored against a queue-based model of the FIFO and strobe protocol.
module tb_step_cmd_loader;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] fifo_level;
    logic [7:0] N;
    logic       WR;
    logic       busy;
    logic       idle;
    logic       err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    step_cmd_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .fifo_level(fifo_level), .N(N), .WR(WR),
        .busy(busy), .idle(idle), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        cmd_data  = d;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_wr(input logic val, input int lim, output int cyc);
        cyc = 0;
        while (WR !== val && cyc < lim) begin
            tick();
            cyc++;
        end
        if (WR !== val) cyc = -1;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (idle !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        if (idle !== 1'b1) cyc = -1;
    endtask

    // Plays the pulse generator for one command: observe the strobe, then pulse busy.
    task automatic serve(output logic [7:0] n_seen, output int low, output bit seen);
        int c;
        n_seen = 8'h00;
        low    = 0;
        seen   = 1'b0;
        wait_wr(1'b0, 60, c);
        if (c >= 0) begin
            seen   = 1'b1;
            n_seen = N;
            while (WR === 1'b0 && low < 6) begin
                tick();
                low++;
            end
            busy = 1'b1;
            repeat (3) tick();
            busy = 1'b0;
        end
    endtask

    // Leaves the loader holding a dummy command with busy high, so later pushes queue up.
    task automatic park();
        int c;
        push(8'hAA);
        wait_wr(1'b0, 20, c);
        wait_wr(1'b1, 20, c);
        busy = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1; cmd_data = 8'h5A; busy = 1'b0;
        tick(); tick();
        n_chk++; if (fifo_level !== 3'd0) $display("FAIL reset_level got %0d want 0", fifo_level); else n_pass++;
        n_chk++; if (WR !== 1'b1) $display("FAIL reset_wr got %b want 1", WR); else n_pass++;
        n_chk++; if (N !== 8'h00) $display("FAIL reset_n got %h want 00", N); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
        n_chk++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cmd_ready); else n_pass++;
        n_chk++; if (idle !== 1'b1) $display("FAIL reset_idle got %b want 1", idle); else n_pass++;
        rst = 1'b0; cmd_valid = 1'b0;
        tick();
        n_chk++; if (idle !== 1'b1 || WR !== 1'b1) $display("FAIL post_reset idle=%b wr=%b want 1 1", idle, WR); else n_pass++;
    endtask

    task automatic test_single();
        int bad = 0;
        push(8'h85);
        n_chk++; if (fifo_level !== 3'd1 || WR !== 1'b1) $display("FAIL single_c1 level=%0d wr=%b want 1 1", fifo_level, WR); else n_pass++;
        tick();
        n_chk++; if (WR !== 1'b0 || N !== 8'h85) $display("FAIL single_c2 wr=%b n=%h want 0 85", WR, N); else n_pass++;
        tick();
        n_chk++; if (WR !== 1'b0 || N !== 8'h85) $display("FAIL single_c3 wr=%b n=%h want 0 85", WR, N); else n_pass++;
        tick();
        n_chk++; if (WR !== 1'b1) $display("FAIL single_c4 wr=%b want 1", WR); else n_pass++;
        busy = 1'b1;
        repeat (20) begin
            tick();
            if (idle !== 1'b0 || WR !== 1'b1) bad++;
        end
        n_chk++; if (bad != 0) $display("FAIL single_busy bad_cycles=%0d want 0", bad); else n_pass++;
        busy = 1'b0;
        tick();
        n_chk++; if (idle !== 1'b1) $display("FAIL single_idle got %b want 1", idle); else n_pass++;
    endtask

    task automatic test_fill_order();
        logic [7:0] n_seen;
        int low, c;
        bit seen;
        park();
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (cmd_ready !== (i < DEPTH)) $display("FAIL fill_ready%0d got %b want %b", i, cmd_ready, (i < DEPTH)); else n_pass++;
            cmd_data = 8'(i + 1); cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        n_chk++; if (fifo_level !== 3'd4 || cmd_ready !== 1'b0) $display("FAIL fill_full level=%0d ready=%b want 4 0", fifo_level, cmd_ready); else n_pass++;
        busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            serve(n_seen, low, seen);
            n_chk++; if (!seen || n_seen !== 8'(i + 1) || low != 2) $display("FAIL fill_issue%0d seen=%0d n=%h low=%0d want 1 %h 2", i, seen, n_seen, low, 8'(i + 1)); else n_pass++;
        end
        wait_wr(1'b0, 12, c);
        n_chk++; if (c != -1) $display("FAIL fill_no_fifth strobe after %0d cycles want none", c); else n_pass++;
        n_chk++; if (idle !== 1'b1 || fifo_level !== 3'd0) $display("FAIL fill_drained idle=%b level=%0d want 1 0", idle, fifo_level); else n_pass++;
    endtask

    task automatic test_same_cycle();
        logic [7:0] n_seen;
        logic [7:0] want [3];
        int low;
        bit seen;
        want[0] = 8'h31; want[1] = 8'h32; want[2] = 8'h33;
        park();
        push(want[0]);
        push(want[1]);
        busy = 1'b0;
        tick();
        n_chk++; if (fifo_level !== 3'd2 || WR !== 1'b1) $display("FAIL pp_before level=%0d wr=%b want 2 1", fifo_level, WR); else n_pass++;
        push(want[2]);
        n_chk++; if (fifo_level !== 3'd2) $display("FAIL pp_level got %0d want 2", fifo_level); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            serve(n_seen, low, seen);
            n_chk++; if (!seen || n_seen !== want[i] || low != 2) $display("FAIL pp_order%0d seen=%0d n=%h low=%0d want 1 %h 2", i, seen, n_seen, low, want[i]); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [7:0] got_q [$];
        int low_q [$];
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    int g = 0;
                    cmd_data = 8'(8'h10 + i); cmd_valid = 1'b1;
                    while (cmd_ready !== 1'b1 && g < 200) begin
                        tick();
                        g++;
                    end
                    tick();
                    cmd_valid = 1'b0;
                end
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    logic [7:0] n_seen;
                    int low;
                    bit seen;
                    serve(n_seen, low, seen);
                    if (seen) begin
                        got_q.push_back(n_seen);
                        low_q.push_back(low);
                    end
                end
            end
        join
        n_chk++; if (got_q.size() != 10) $display("FAIL wrap_count got %0d want 10", got_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size(); i++) begin
            n_chk++; if (got_q[i] !== 8'(8'h10 + i) || low_q[i] != 2) $display("FAIL wrap_item%0d n=%h low=%0d want %h 2", i, got_q[i], low_q[i], 8'(8'h10 + i)); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        logic [7:0] n_seen;
        int low, c;
        bit seen;
        push(8'h41);
        push(8'h42);
        n_chk++; if (WR !== 1'b0 || N !== 8'h41) $display("FAIL to_first wr=%b n=%h want 0 41", WR, N); else n_pass++;
        wait_wr(1'b1, 10, c);
        repeat (TIMEOUT - 1) tick();
        n_chk++; if (err !== 1'b0) $display("FAIL to_early err=%b want 0", err); else n_pass++;
        tick();
        n_chk++; if (err !== 1'b1) $display("FAIL to_err got %b want 1", err); else n_pass++;
        n_chk++; if (fifo_level !== 3'd1 || WR !== 1'b1) $display("FAIL to_idle level=%0d wr=%b want 1 1", fifo_level, WR); else n_pass++;
        tick();
        n_chk++; if (WR !== 1'b0 || N !== 8'h42) $display("FAIL to_next wr=%b n=%h want 0 42", WR, N); else n_pass++;
        serve(n_seen, low, seen);
        n_chk++; if (low != 2 || err !== 1'b1) $display("FAIL to_next_strobe low=%0d err=%b want 2 1", low, err); else n_pass++;
    endtask

    task automatic test_reset_in_stb2();
        int c;
        push(8'h77);
        tick();
        n_chk++; if (WR !== 1'b0) $display("FAIL rs_stb2 wr=%b want 0", WR); else n_pass++;
        rst = 1'b1;
        tick();
        n_chk++; if (WR !== 1'b1 || fifo_level !== 3'd0 || N !== 8'h00) $display("FAIL rs_after wr=%b level=%0d n=%h want 1 0 00", WR, fifo_level, N); else n_pass++;
        n_chk++; if (err !== 1'b0 || idle !== 1'b1) $display("FAIL rs_flags err=%b idle=%b want 0 1", err, idle); else n_pass++;
        rst = 1'b0;
        wait_wr(1'b0, 12, c);
        n_chk++; if (c != -1) $display("FAIL rs_no_strobe strobe after %0d cycles want none", c); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] exp_q [$];
        logic [7:0] e;
        logic [7:0] d_prev;
        logic prev_wr, v_prev, exp_rdy;
        int acc, ld, lvl_before, low, bw, bh;
        acc = 0; ld = 0; low = 0; bw = -1; bh = 0; prev_wr = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            lvl_before = acc - ld;
            if (cyc < 400) begin
                cmd_valid = ($urandom_range(0, 2) != 0);
                cmd_data  = 8'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            v_prev = cmd_valid;
            d_prev = cmd_data;
            tick();
            if (v_prev && lvl_before < DEPTH) begin
                exp_q.push_back(d_prev);
                acc++;
            end
            if (prev_wr === 1'b1 && WR === 1'b0) begin
                ld++;
                low = 1;
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rnd_order cyc=%0d n=%h issued with empty model queue", cyc, N);
                end else begin
                    e = exp_q.pop_front();
                    if (N !== e) $display("FAIL rnd_order cyc=%0d got %h want %h", cyc, N, e); else n_pass++;
                end
            end else if (WR === 1'b0) begin
                low++;
            end
            if (prev_wr === 1'b0 && WR === 1'b1) begin
                n_chk++; if (low != 2) $display("FAIL rnd_strobe cyc=%0d low=%0d want 2", cyc, low); else n_pass++;
                bw = $urandom_range(0, 3);
                bh = $urandom_range(1, 5);
            end
            prev_wr = WR;
            exp_rdy = ((acc - ld) < DEPTH);
            n_chk++; if (fifo_level !== 3'(acc - ld)) $display("FAIL rnd_level cyc=%0d got %0d want %0d", cyc, fifo_level, acc - ld); else n_pass++;
            n_chk++; if (cmd_ready !== exp_rdy) $display("FAIL rnd_ready cyc=%0d got %b want %b", cyc, cmd_ready, exp_rdy); else n_pass++;
            if (bw > 0) begin
                bw--;
            end else if (bw == 0) begin
                busy = 1'b1;
                bw = -1;
            end else if (busy === 1'b1 && bh > 0) begin
                bh--;
                if (bh == 0) busy = 1'b0;
            end
        end
        n_chk++; if (exp_q.size() != 0 || acc < 10) $display("FAIL rnd_drain left=%0d accepted=%0d want 0 >=10", exp_q.size(), acc); else n_pass++;
        n_chk++; if (idle !== 1'b1 || err !== 1'b0) $display("FAIL rnd_end idle=%b err=%b want 1 0", idle, err); else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        test_reset();
        test_single();
        wait_idle(c);
        test_fill_order();
        wait_idle(c);
        test_same_cycle();
        wait_idle(c);
        test_wrap();
        wait_idle(c);
        n_chk++; if (c < 0) $display("FAIL idle_before_timeout got idle=%b want 1", idle); else n_pass++;
        test_timeout();
        wait_idle(c);
        test_reset_in_stb2();
        wait_idle(c);
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
